// File: rtl/stage_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// stage_sequencer_pkg
//   Shared definitions for the solver+draw run/done sequencer:
//   - sequencer state encoding
//   - default number of sequenced stages
//   - symbolic names for the stage indices (getElement ... drawCircuit)
//   - small decode helper used by the top level
// ----------------------------------------------------------------------------
package stage_sequencer_pkg;

    localparam int DEFAULT_NUM_STAGES = 11;

    typedef enum logic [2:0] {
        ST_START      = 3'd0,
        ST_START_WAIT = 3'd1,
        ST_RUN        = 3'd2,
        ST_STEP_ARM   = 3'd3,
        ST_STEP_REL   = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } seq_state_t;

    // Position of each processing block in the run/done vectors.
    typedef enum logic [4:0] {
        S_GET_ELEMENT   = 5'd0,
        S_PARSE_NODES   = 5'd1,
        S_BUILD_MATRIX  = 5'd2,
        S_STAMP_SOURCES = 5'd3,
        S_FACTORIZE     = 5'd4,
        S_SOLVE         = 5'd5,
        S_CALC_CURRENTS = 5'd6,
        S_SCALE_VIEW    = 5'd7,
        S_PLACE_NODES   = 5'd8,
        S_DRAW_WIRES    = 5'd9,
        S_DRAW_CIRCUIT  = 5'd10
    } stage_id_t;

    // States in which a stage sequence is in progress (running or paused).
    function automatic logic isBusyState(input seq_state_t s);
        return (s == ST_RUN) || (s == ST_STEP_ARM) || (s == ST_STEP_REL);
    endfunction

endpackage

// File: rtl/stage_sequencer_next_stage_finder.sv
// ----------------------------------------------------------------------------
// next_stage_finder
//   Combinational search over the enable mask.
//   startMode = 0 : lowest set bit of en_mask strictly above idx
//   startMode = 1 : lowest set bit of en_mask overall (idx ignored)
//
// Ports
//   en_mask   in  NUM_STAGES  stages that take part in the sequence
//   idx       in  IDX_W       currently active stage index
//   startMode in  1           search from bit 0 instead of above idx
//   next_idx  out IDX_W       index found (0 when nothing found)
//   found     out 1           a qualifying set bit exists
// ----------------------------------------------------------------------------
module next_stage_finder #(
    parameter int NUM_STAGES = 11,
    parameter int IDX_W      = 5
) (
    input  logic [NUM_STAGES-1:0] en_mask,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  startMode,
    output logic [IDX_W-1:0]      next_idx,
    output logic                  found
);

    // Walking from the top bit down means the last hit written is the
    // lowest qualifying index.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (en_mask[i] && (startMode || (IDX_W'(i) > idx))) begin
                next_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// ----------------------------------------------------------------------------
// stage_sequencer
//   Top-level run/done sequencer for the solver+draw pipeline. Steps the
//   enabled processing blocks one at a time in index order through a one-hot
//   run vector, advancing on the active block's done bit. Supports a per-run
//   skip mask, single-step debug pausing, a watchdog and an abort input.
//
// Ports
//   clk                in   1           system clock
//   program_reset_n    in   1           asynchronous active-low reset
//   press_start        in   1           start/step key (level, synchronised)
//   abort              in   1           forces ERROR while a sequence runs
//   step_mode          in   1           pause after each stage for a key press
//   stage_enable       in   NUM_STAGES  stages to execute, latched at launch
//   stage_done         in   NUM_STAGES  per-stage completion (level or pulse)
//   program_initialize out  1           high in START
//   run_clearScreen    out  1           high in START
//   stage_run          out  NUM_STAGES  one-hot run enable of active stage
//   busy               out  1           sequence running or paused
//   finished           out  1           sequence complete
//   error              out  1           sequence stopped by abort/watchdog
//   error_stage        out  IDX_W       stage active when ERROR was entered
//   timed_out          out  1           ERROR cause: 1 watchdog, 0 abort
//   current_stage      out  IDX_W       active/last stage index for display
// ----------------------------------------------------------------------------
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES     = DEFAULT_NUM_STAGES,
    parameter int IDX_W          = 5,
    parameter int TIMEOUT_W      = 24,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  program_reset_n,
    input  logic                  press_start,
    input  logic                  abort,
    input  logic                  step_mode,
    input  logic [NUM_STAGES-1:0] stage_enable,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  program_initialize,
    output logic                  run_clearScreen,
    output logic [NUM_STAGES-1:0] stage_run,
    output logic                  busy,
    output logic                  finished,
    output logic                  error,
    output logic [IDX_W-1:0]      error_stage,
    output logic                  timed_out,
    output logic [IDX_W-1:0]      current_stage
);

    // A zero timeout disables the watchdog; the limit is then never used.
    localparam bit                   WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST =
        TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

    seq_state_t            state,     stateNext;
    logic [IDX_W-1:0]      idx,       idxNext;
    logic [NUM_STAGES-1:0] enMask,    enMaskNext;
    logic [TIMEOUT_W-1:0]  wdog,      wdogNext;
    logic [IDX_W-1:0]      errStage,  errStageNext;
    logic                  timedOut,  timedOutNext;

    logic [NUM_STAGES-1:0] runVec;
    logic                  doneHit;
    logic                  wdogExpired;
    logic [NUM_STAGES-1:0] finderMask;
    logic                  finderStart;
    logic [IDX_W-1:0]      nextIdx;
    logic                  nextFound;

    // One-hot select of the active stage; only its done bit is looked at.
    assign runVec      = NUM_STAGES'(1) << idx;
    assign doneHit     = |(stage_done & runVec);
    assign wdogExpired = WDOG_EN && (wdog == WDOG_LAST);

    // At launch the mask register is not loaded yet, so search the live
    // enable inputs from bit 0; afterwards search the latched mask above idx.
    assign finderStart = (state == ST_START_WAIT);
    assign finderMask  = finderStart ? stage_enable : enMask;

    next_stage_finder #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (IDX_W)
    ) uFinder (
        .en_mask   (finderMask),
        .idx       (idx),
        .startMode (finderStart),
        .next_idx  (nextIdx),
        .found     (nextFound)
    );

    always_ff @(posedge clk or negedge program_reset_n) begin
        if (!program_reset_n) begin
            state    <= ST_START;
            idx      <= '0;
            enMask   <= '0;
            wdog     <= '0;
            errStage <= '0;
            timedOut <= 1'b0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            enMask   <= enMaskNext;
            wdog     <= wdogNext;
            errStage <= errStageNext;
            timedOut <= timedOutNext;
        end
    end

    // wdogNext defaults to zero: every path into RUN (launch, advance to the
    // next stage, resume from step pause) therefore starts a fresh count, and
    // only a cycle spent waiting in RUN on the same stage increments it.
    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        enMaskNext   = enMask;
        wdogNext     = '0;
        errStageNext = errStage;
        timedOutNext = timedOut;

        unique case (state)
            ST_START: begin
                if (press_start) begin
                    stateNext = ST_START_WAIT;
                end
            end

            ST_START_WAIT: begin
                if (!press_start) begin
                    enMaskNext = stage_enable;
                    if (nextFound) begin
                        idxNext   = nextIdx;
                        stateNext = ST_RUN;
                    end else begin
                        stateNext = ST_DONE;
                    end
                end
            end

            // Priority: abort, then the active stage's done, then watchdog.
            ST_RUN: begin
                if (abort) begin
                    stateNext    = ST_ERROR;
                    errStageNext = idx;
                    timedOutNext = 1'b0;
                end else if (doneHit) begin
                    if (!nextFound) begin
                        stateNext = ST_DONE;
                    end else if (step_mode) begin
                        idxNext   = nextIdx;
                        stateNext = ST_STEP_ARM;
                    end else begin
                        idxNext   = nextIdx;
                        stateNext = ST_RUN;
                    end
                end else if (wdogExpired) begin
                    stateNext    = ST_ERROR;
                    errStageNext = idx;
                    timedOutNext = 1'b1;
                end else begin
                    wdogNext = (wdog == {TIMEOUT_W{1'b1}}) ? wdog : (wdog + 1'b1);
                end
            end

            ST_STEP_ARM: begin
                if (abort) begin
                    stateNext    = ST_ERROR;
                    errStageNext = idx;
                    timedOutNext = 1'b0;
                end else if (press_start) begin
                    stateNext = ST_STEP_REL;
                end
            end

            ST_STEP_REL: begin
                if (abort) begin
                    stateNext    = ST_ERROR;
                    errStageNext = idx;
                    timedOutNext = 1'b0;
                end else if (!press_start) begin
                    stateNext = ST_RUN;
                end
            end

            ST_DONE, ST_ERROR: begin
                if (press_start) begin
                    stateNext    = ST_START;
                    timedOutNext = 1'b0;
                end
            end

            default: begin
                stateNext = ST_START;
            end
        endcase
    end

    // Moore outputs; because state is reset asynchronously, stage_run drops
    // as soon as reset asserts.
    assign program_initialize = (state == ST_START);
    assign run_clearScreen    = (state == ST_START);
    assign stage_run          = (state == ST_RUN) ? runVec : '0;
    assign busy               = isBusyState(state);
    assign finished           = (state == ST_DONE);
    assign error              = (state == ST_ERROR);
    assign error_stage        = errStage;
    assign timed_out          = timedOut;
    assign current_stage      = idx;

endmodule

// File: tb/tb_stage_sequencer.sv
// ----------------------------------------------------------------------------
// tb_stage_sequencer
//   Directed bench for stage_sequencer. Expected stage launch order is pushed
//   into a queue before each run and popped whenever a new run bit appears.
// ----------------------------------------------------------------------------
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    localparam int NS = 11;
    localparam int IW = 5;
    localparam int TW = 24;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          program_reset_n;
    logic          press_start;
    logic          abort;
    logic          step_mode;
    logic [NS-1:0] stage_enable;
    logic [NS-1:0] stage_done;
    logic          program_initialize;
    logic          run_clearScreen;
    logic [NS-1:0] stage_run;
    logic          busy;
    logic          finished;
    logic          error;
    logic [IW-1:0] error_stage;
    logic          timed_out;
    logic [IW-1:0] current_stage;

    always #5 clk = ~clk;

    stage_sequencer #(
        .NUM_STAGES     (NS),
        .IDX_W          (IW),
        .TIMEOUT_W      (TW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .program_reset_n    (program_reset_n),
        .press_start        (press_start),
        .abort              (abort),
        .step_mode          (step_mode),
        .stage_enable       (stage_enable),
        .stage_done         (stage_done),
        .program_initialize (program_initialize),
        .run_clearScreen    (run_clearScreen),
        .stage_run          (stage_run),
        .busy               (busy),
        .finished           (finished),
        .error              (error),
        .error_stage        (error_stage),
        .timed_out          (timed_out),
        .current_stage      (current_stage)
    );

    int tests = 0;
    int fails = 0;
    int expQ[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From START: press then release; the first stage runs after release.
    task automatic startRun();
        press_start = 1'b1;
        @(negedge clk);
        press_start = 1'b0;
    endtask

    // From DONE/ERROR back to START and check the idle START outputs.
    task automatic gotoStart(input string tag);
        press_start = 1'b1;
        @(negedge clk);
        press_start = 1'b0;
        chk({tag, "_init"}, 32'(program_initialize), 1);
        chk({tag, "_error_clr"}, 32'(error), 0);
        chk({tag, "_timedout_clr"}, 32'(timed_out), 0);
        @(negedge clk);
        chk({tag, "_init_hold"}, 32'(program_initialize), 1);
    endtask

    // Responds to run bits: pulses done 3 cycles after a run rises (for
    // stages in respondMask), checks launch order against expQ, and returns
    // when stage_run falls to zero (done, error or step pause).
    task automatic runStages(input logic [NS-1:0] respondMask,
                             input logic [NS-1:0] doneAlways,
                             input int abortStage, input int resetStage,
                             input bit checkGap, input int budget,
                             output int firstRise, output int lastRise,
                             output int endIter);
        logic [NS-1:0] prevRun;
        int            curStage;
        int            rise;
        bit            sawRun;
        int            e;
        prevRun   = '0;
        curStage  = -1;
        rise      = -1;
        sawRun    = 1'b0;
        firstRise = -1;
        lastRise  = -1;
        endIter   = -1;
        for (int it = 0; it < budget; it++) begin
            @(negedge clk);
            if ((stage_run != prevRun) && (stage_run != '0)) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_run", 32'(stage_run), 0);
                end else begin
                    e = expQ.pop_front();
                    chk("run_order", 32'(stage_run), 32'(1) << e);
                end
                for (int b = 0; b < NS; b++) if (stage_run[b]) curStage = b;
                if (checkGap && sawRun) chk("no_gap", 32'(it - rise), 4);
                rise   = it;
                sawRun = 1'b1;
                if (firstRise < 0) firstRise = it;
                lastRise = it;
            end
            prevRun = stage_run;
            if (sawRun ? (stage_run == '0) : (finished || error)) begin
                endIter = it;
                break;
            end
            if ((resetStage >= 0) && (curStage == resetStage) && (it == rise + 1)) begin
                program_reset_n = 1'b0;
                #1;
                chk("reset_async_run", 32'(stage_run), 0);
                endIter = it;
                break;
            end
            stage_done = doneAlways;
            abort      = 1'b0;
            if ((curStage >= 0) && (it == rise + 3)) begin
                if (respondMask[curStage]) stage_done = stage_done | (NS'(1) << curStage);
                if (curStage == abortStage) abort = 1'b1;
            end
        end
        stage_done = '0;
        abort      = 1'b0;
        chk("run_completed", 32'(endIter >= 0), 1);
    endtask

    int f, l, en;

    initial begin
        program_reset_n = 1'b0;
        press_start     = 1'b0;
        abort           = 1'b0;
        step_mode       = 1'b0;
        stage_enable    = '0;
        stage_done      = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_init", 32'(program_initialize), 1);
        chk("rst_clear", 32'(run_clearScreen), 1);
        chk("rst_run", 32'(stage_run), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_finished", 32'(finished), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_stage", 32'(error_stage), 0);
        chk("rst_timed_out", 32'(timed_out), 0);
        chk("rst_cur_stage", 32'(current_stage), 0);
        program_reset_n = 1'b1;
        @(negedge clk);
        chk("idle_init", 32'(program_initialize), 1);

        // All stages enabled, back-to-back sequencing 0..10
        stage_enable = '1;
        for (int i = S_GET_ELEMENT; i <= S_DRAW_CIRCUIT; i++) expQ.push_back(i);
        startRun();
        runStages('1, '0, -1, -1, 1'b1, 200, f, l, en);
        chk("all_finished", 32'(finished), 1);
        chk("all_busy", 32'(busy), 0);
        chk("all_cur_stage", 32'(current_stage), 32'(S_DRAW_CIRCUIT));
        chk("all_queue_empty", 32'(expQ.size()), 0);
        gotoStart("all");

        // Skip mask 0b101 with done[1] held high throughout
        stage_enable = 11'b000_0000_0101;
        stage_done   = 11'b000_0000_0010;
        expQ.push_back(0);
        expQ.push_back(2);
        startRun();
        runStages('1, 11'b000_0000_0010, -1, -1, 1'b1, 100, f, l, en);
        chk("skip_finished", 32'(finished), 1);
        chk("skip_cur_stage", 32'(current_stage), 2);
        chk("skip_queue_empty", 32'(expQ.size()), 0);
        gotoStart("skip");

        // Watchdog: stage 3 never completes
        stage_enable = '1;
        for (int i = 0; i <= 3; i++) expQ.push_back(i);
        startRun();
        runStages(~(NS'(1) << 3), '0, -1, -1, 1'b1, 200, f, l, en);
        chk("wdog_error", 32'(error), 1);
        chk("wdog_timed_out", 32'(timed_out), 1);
        chk("wdog_err_stage", 32'(error_stage), 3);
        chk("wdog_latency", 32'(en - l), TO);
        chk("wdog_busy", 32'(busy), 0);
        chk("wdog_queue_empty", 32'(expQ.size()), 0);
        gotoStart("wdog");

        // Single-step mode over stages 0 and 1
        stage_enable = 11'b000_0000_0011;
        step_mode    = 1'b1;
        expQ.push_back(0);
        expQ.push_back(1);
        startRun();
        runStages('1, '0, -1, -1, 1'b0, 100, f, l, en);
        chk("step_paused_busy", 32'(busy), 1);
        chk("step_paused_run", 32'(stage_run), 0);
        chk("step_paused_idx", 32'(current_stage), 1);
        repeat (3) @(negedge clk);
        chk("step_wait_run", 32'(stage_run), 0);
        press_start = 1'b1;
        @(negedge clk);
        chk("step_held_run", 32'(stage_run), 0);
        press_start = 1'b0;
        runStages('1, '0, -1, -1, 1'b0, 100, f, l, en);
        chk("step_resume_latency", 32'(f), 0);
        chk("step_finished", 32'(finished), 1);
        chk("step_queue_empty", 32'(expQ.size()), 0);
        step_mode = 1'b0;
        gotoStart("step");

        // Abort in the same cycle as done[2]
        stage_enable = '1;
        for (int i = 0; i <= 2; i++) expQ.push_back(i);
        startRun();
        runStages('1, '0, 2, -1, 1'b1, 100, f, l, en);
        chk("abort_error", 32'(error), 1);
        chk("abort_timed_out", 32'(timed_out), 0);
        chk("abort_err_stage", 32'(error_stage), 2);
        chk("abort_queue_empty", 32'(expQ.size()), 0);
        gotoStart("abort");

        // Empty mask goes straight to DONE
        stage_enable = '0;
        startRun();
        runStages('1, '0, -1, -1, 1'b0, 20, f, l, en);
        chk("empty_finished", 32'(finished), 1);
        chk("empty_no_run", 32'(f), 32'(-1));
        gotoStart("empty");

        // Reset asserted while stage 5 is running
        stage_enable = '1;
        for (int i = 0; i <= 5; i++) expQ.push_back(i);
        startRun();
        runStages('1, '0, -1, 5, 1'b1, 100, f, l, en);
        chk("midrst_init", 32'(program_initialize), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cur_stage", 32'(current_stage), 0);
        chk("midrst_queue_empty", 32'(expQ.size()), 0);
        @(negedge clk);
        program_reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_init", 32'(program_initialize), 1);
        chk("midrst_release_run", 32'(stage_run), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
